// File: rtl/alu_mdu_pkg.sv
// Shared op-select encodings for the execute-stage ALU and its HI/LO multiply/divide unit.
package alu_mdu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [OP_W-1:0] OP_AND   = 5'd2;
  localparam logic [OP_W-1:0] OP_OR    = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_SLL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL   = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA   = 5'd8;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd9;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd10;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'd11;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'd12;
  localparam logic [OP_W-1:0] OP_MTHI  = 5'd13;
  localparam logic [OP_W-1:0] OP_MTLO  = 5'd14;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd15;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd16;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd17;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd18;

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide engine on operand magnitudes,
// with sign fix-up applied in the FIX state.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c,
  output logic             res_vld_c,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quot, rem;

  assign mag_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // One shift-add step: conditionally add multiplicand to the upper half, shift right with carry.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

  // One restoring step: remainder in the upper half, dividend/quotient bits in the lower half.
  assign div_tmp  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign prod = (neg_a_q ^ neg_b_q) ? -p_q : p_q;
  assign quot = p_q[WIDTH-1:0];
  assign rem  = p_q[2*WIDTH-1:WIDTH];

  // Divide-by-zero leaves |dividend| as remainder; re-applying the dividend sign restores it.
  always_comb begin
    if (is_div_q) begin
      res_lo_c = div0_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quot : quot);
      res_hi_c = neg_a_q ? -rem : rem;
    end else begin
      res_lo_c = prod[WIDTH-1:0];
      res_hi_c = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    div0_d    = div0_q;
    res_vld_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = is_div_i;
          neg_a_d  = is_signed_i && a_i[WIDTH-1];
          neg_b_d  = is_signed_i && b_i[WIDTH-1];
          div0_d   = is_div_i && (b_i == '0);
          opnd_d   = is_div_i ? mag_b : mag_a;
          p_d      = {{WIDTH{1'b0}}, (is_div_i ? mag_a : mag_b)};
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          p_d   = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d   = S_IDLE;
        res_vld_c = !flush_i;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = res_vld_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational ops, HI/LO register pair with MTHI/MTLO, and the iterative MDU.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] s,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] c,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             md_vld, md_busy, md_done;
  logic             is_md, is_div, is_signed, issue_ok;

  assign shamt = a[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    c        = '0;
    overflow = 1'b0;
    case (s)
      SEL_W'(OP_ADD): begin
        c        = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SEL_W'(OP_SUB): begin
        c        = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      SEL_W'(OP_AND):  c = a & b;
      SEL_W'(OP_OR):   c = a | b;
      SEL_W'(OP_XOR):  c = a ^ b;
      SEL_W'(OP_NOR):  c = ~(a | b);
      SEL_W'(OP_SLL):  c = b << shamt;
      SEL_W'(OP_SRL):  c = b >> shamt;
      SEL_W'(OP_SRA):  c = $signed(b) >>> shamt;
      SEL_W'(OP_SLT):  c = WIDTH'($signed(a) < $signed(b));
      SEL_W'(OP_SLTU): c = WIDTH'(a < b);
      SEL_W'(OP_MFHI): c = hi_q;
      SEL_W'(OP_MFLO): c = lo_q;
      default:         c = '0;
    endcase
  end

  assign zero = (c == '0);

  assign is_div    = (s == SEL_W'(OP_DIV)) || (s == SEL_W'(OP_DIVU));
  assign is_signed = (s == SEL_W'(OP_DIV)) || (s == SEL_W'(OP_MULT));
  assign is_md     = is_div || (s == SEL_W'(OP_MULT)) || (s == SEL_W'(OP_MULTU));
  assign issue_ok  = start && !flush && !md_busy;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (issue_ok && is_md),
    .flush_i     (flush),
    .is_div_i    (is_div),
    .is_signed_i (is_signed),
    .a_i         (a),
    .b_i         (b),
    .res_hi_c    (md_hi),
    .res_lo_c    (md_lo),
    .res_vld_c   (md_vld),
    .busy_o      (md_busy),
    .done_o      (md_done)
  );

  // MDU result and MTHI/MTLO never coincide: moves are only accepted while idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_vld) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (issue_ok && (s == SEL_W'(OP_MTHI))) begin
      hi_d = a;
    end else if (issue_ok && (s == SEL_W'(OP_MTLO))) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = md_busy;
  assign done = md_done;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu with hand-computed expected values.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk, rst, start, flush;
  logic [31:0] a, b, c, hi, lo;
  logic [4:0]  s;
  logic        overflow, zero, busy, done;
  int          checks, errors;

  alu_mdu #(.WIDTH(32), .SEL_W(5)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .start(start), .flush(flush),
    .c(c), .overflow(overflow), .zero(zero), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    s = op; a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts busy cycles starting from the first busy cycle; bounded.
  task automatic wait_done(output int cyc, output logic got);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
    got = done;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; s = OP_ADD; a = '0; b = '0;
    #12;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b required 0/0/0/0", hi, lo, busy, done);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [4:0]  ops [9]  = '{OP_SUB, OP_ADD, OP_SLT, OP_SLTU, OP_SRA, OP_SLL, OP_NOR, OP_AND, 5'd31};
    logic [31:0] av  [9]  = '{32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd4, 32'd0, 32'hF0, 32'h1};
    logic [31:0] bv  [9]  = '{32'd7, 32'd1, 32'd1, 32'd1, 32'h80000000, 32'd1, 32'd0, 32'h0F, 32'h1};
    logic [31:0] ec  [9]  = '{32'hFFFFFFFE, 32'h80000000, 32'd1, 32'd0, 32'hF8000000, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic        eo  [9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      s = ops[i]; a = av[i]; b = bv[i];
      #1;
      checks++;
      if (c !== ec[i] || overflow !== eo[i] || zero !== (ec[i] == 32'h0)) begin
        errors++;
        $display("FAIL alu[%0d]: c=%h ovf=%b zero=%b required c=%h ovf=%b zero=%b",
                 i, c, overflow, zero, ec[i], eo[i], (ec[i] == 32'h0));
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'h1234, 32'h0);
    checks++;
    if (hi !== 32'h1234) begin
      errors++; $display("FAIL mthi: hi=%h required 00001234", hi);
    end
    issue(OP_MTLO, 32'hABCD, 32'h0);
    checks++;
    if (lo !== 32'hABCD) begin
      errors++; $display("FAIL mtlo: lo=%h required 0000abcd", lo);
    end
  endtask

  task automatic test_mult();
    int cyc; logic got;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    s = OP_MFHI; #1;
    checks++;
    if (c !== 32'h1234) begin
      errors++; $display("FAIL mfhi_busy: c=%h required 00001234", c);
    end
    s = OP_ADD; a = 32'd2; b = 32'd3; #1;
    checks++;
    if (c !== 32'd5) begin
      errors++; $display("FAIL add_busy: c=%h required 00000005", c);
    end
    issue(OP_MTHI, 32'h5555, 32'h0);
    wait_done(cyc, got);
    cyc++;
    checks++;
    if (cyc !== 33 || got !== 1'b1) begin
      errors++; $display("FAIL mult_timing: busy_cycles=%0d done=%b required 33 1", cyc, got);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult: hi=%h lo=%h required ffffffff ffffffeb", hi, lo);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_md_vectors();
    logic [4:0]  ops [6] = '{OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] av  [6] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'd7};
    logic [31:0] bv  [6] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE};
    logic [31:0] eh  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'h0, 32'd2, 32'd1};
    logic [31:0] el  [6] = '{32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd14, 32'hFFFFFFFD};
    int cyc; logic got;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc, got);
      checks++;
      if (got !== 1'b1 || hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL md[%0d]: done=%b hi=%h lo=%h required 1 %h %h", i, got, hi, lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic seen;
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy: busy=%b required 0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0 || hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL flush: done_seen=%b hi=%h lo=%h required 0 00000001 fffffffd", seen, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic got;
    issue(OP_MULTU, 32'd3, 32'd3);
    step();
    issue(OP_DIVU, 32'd9, 32'd1);
    wait_done(cyc, got);
    cyc += 2;
    checks++;
    if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd9) begin
      errors++; $display("FAIL start_busy: cycles=%0d hi=%h lo=%h required 33 0 9", cyc, hi, lo);
    end
    issue(OP_MULTU, 32'd4, 32'd5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    wait_done(cyc, got);
    checks++;
    if (got !== 1'b1 || hi !== 32'd0 || lo !== 32'd20) begin
      errors++; $display("FAIL b2b: done=%b hi=%h lo=%h required 1 0 20", got, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    issue(OP_MTHI, 32'h77, 32'h0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_quiet: activity=%b required 0", seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_mthi_mtlo();
    test_mult();
    test_md_vectors();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage ALU with an integrated iterative multiply/divide unit that owns the HI/LO register pair. Single-cycle ops (arithmetic, logic, shifts, signed/unsigned compare) produce `c` combinationally. MULT/MULTU/DIV/DIVU run as a multi-cycle state machine that writes HI/LO. The pipeline's hazard unit uses `busy` to stall HI/LO consumers.

## Interface
- `WIDTH`, 32: datapath width; must be a power of two, at least 8.
- `SEL_W`, 5: width of the op select `s`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `a` in WIDTH: operand A; for shifts, its low log2(WIDTH) bits are the shift amount.
- `b` in WIDTH: operand B; for shifts, the value shifted.
- `s` in SEL_W: op select, encoded in the shared op-code include.
- `start` in 1: issue strobe for HI/LO-writing ops (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `flush` in 1: abort an in-flight multiply/divide.
- `c` out WIDTH: combinational result.
- `overflow` out 1: signed overflow of ADD/SUB; 0 for every other op.
- `zero` out 1: `c == 0`.
- `busy` out 1: multiply/divide in flight.
- `done` out 1: one-cycle pulse; the new HI/LO are visible in this cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Combinational ops:
  - ADD, SUB: modulo 2^WIDTH.
  - AND, OR, XOR, NOR.
  - SLL, SRL, SRA: shift `b` by `a[log2(WIDTH)-1:0]`; SRA is arithmetic.
  - SLT: signed compare; SLTU: unsigned compare. Both give 1 or 0, zero-extended.
  - MFHI returns `hi`; MFLO returns `lo`.
  - Undefined select gives `c` = 0.
- MTHI and MTLO with `start` while not busy load `a` into HI or LO at that clock edge. They are ignored while busy.
- FSM states are IDLE, CALC and FIX.
- IDLE to CALC: `start` asserted with a MULT/MULTU/DIV/DIVU select. At that edge the unit latches the operand magnitudes, the sign flags and the op, and clears the iteration counter.
- CALC: one radix-2 step per cycle.
  - Multiply uses shift-add.
  - Divide uses restoring division.
  - CALC moves to FIX after exactly WIDTH steps.
- FIX to IDLE: sign correction is applied, HI/LO are written at the edge, and `done` is set for the next cycle.
- Multiply writes the 2*WIDTH-bit product: {HI, LO}.
- Divide writes LO = quotient and HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ -1: LO = most-negative, HI = 0.
- Divide by zero (both signed and unsigned): LO = all ones, HI = dividend.
- `start` while busy is ignored; no queueing. `start` with any other select does nothing.
- `flush` while in CALC or FIX returns the FSM to IDLE at the next edge. HI/LO are unchanged and no `done` pulse is produced. `flush` in IDLE has no effect.
- `flush` and `start` in the same cycle: `flush` wins, nothing is issued.
- Combinational ops stay fully usable while busy. MFHI/MFLO while busy return the old HI/LO; stalling these is the hazard unit's job.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, FSM = IDLE. Reset asserted mid-operation aborts it, with the same result as `flush` but asynchronous.
- Combinational ops have zero latency.
- MTHI/MTLO: the new value is visible the cycle after issue.
- Multiply/divide, with issue at edge E0:
  - `busy` is high from E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
  - HI/LO update at E(WIDTH+1).
  - `done` is high for exactly one cycle after E(WIDTH+1), with `busy` low in that cycle.
- Back-to-back: a new `start` is accepted in the `done` cycle. Total throughput is WIDTH+2 cycles per operation.

## Structure
- Op-select encodings and SEL_W go in the shared op-code include alongside the existing ALU selection macros. This covers all ops, including the HI/LO ops.
- Sub-module `mdu_iter` is the iterative engine. It holds the FSM, counter, partial product/remainder registers and sign fix-up. Interface: operands, op, `start`, `flush`, result pair, `busy`, `done`.
- The top level contains the combinational ALU, the HI/LO registers and the MTHI/MTLO path.

## Test plan
- After reset, `hi` = `lo` = 0 and `busy` = 0. With SUB, a = 5, b = 7: `c` = 0xFFFFFFFE, `overflow` = 0. ADD, a = 0x7FFFFFFF, b = 1: `overflow` = 1.
- SLT, a = 0xFFFFFFFF, b = 1: `c` = 1. SLTU with the same operands: `c` = 0. SRA, a = 4, b = 0x80000000: `c` = 0xF8000000.
- MULT, a = -3, b = 7: `busy` for 33 cycles, `done` in cycle 34, {HI, LO} = 0xFFFFFFFF_FFFFFFEB. MULTU, a = b = 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 1.
- DIV, a = -7, b = 2: LO = -3, HI = -1. DIVU, a = 7, b = 0: LO = 0xFFFFFFFF, HI = 7. DIV, a = 0x80000000, b = -1: LO = 0x80000000, HI = 0.
- Flush in cycle 10 of a MULT: no `done`, HI/LO keep their prior values. A `start` during `busy` is ignored. A `start` in the `done` cycle is accepted.
- MTHI with a = 0x1234 while idle: `hi` = 0x1234 next cycle. Repeated while busy: ignored. `rst` pulsed low mid-DIV: all outputs return to their reset values immediately.
